// File: rtl/cu_sequencer.sv
// cu_sequencer: multi-cycle control sequencer.
//
// Accepts one opcode per instruction over a valid/ready handshake and walks it
// through DECODE -> EXEC -> (MEM) -> WB. The control word is looked up once in
// DECODE and held, registered, for the rest of the instruction. The sequencer
// stalls in EXEC for ALU ops until alu_done, and in MEM until mem_ack. It traps
// on illegal opcodes and on waits that exceed TIMEOUT cycles, and it counts
// retired instructions.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   instr_valid/ready opcode handshake; ready is high only in IDLE
//   opcode            instruction opcode, latched at the accept edge
//   alu_done          ALU completion, only looked at in EXEC for ALU ops
//   mem_ack           memory completion, only looked at in MEM
//   mem_req           high for every MEM cycle
//   clear_trap        leaves TRAP and clears the sticky flags
//   control_signals   registered control word
//   state             IDLE=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7
//   retire            one-cycle pulse while in WB
//   illegal, timeout  sticky trap causes
//   ops_retired       retired-instruction count, wraps
module cu_sequencer #(
  parameter int OPW     = 6,
  parameter int CTRLW   = 8,
  parameter int NUM_OPS = 27,
  parameter int TIMEOUT = 15,
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic             alu_done,
  input  logic             mem_ack,
  output logic             mem_req,
  input  logic             clear_trap,
  output logic [CTRLW-1:0] control_signals,
  output logic [2:0]       state,
  output logic             retire,
  output logic             illegal,
  output logic             timeout,
  output logic [CNTW-1:0]  ops_retired
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [1:0] {C_BR, C_MEM, C_MOV, C_ALU} cls_e;

  typedef struct packed {
    logic       legal;
    cls_e       cls;
    logic [7:0] ctrl;
  } dec_t;

  // Opcode -> {legality, execution class, 8-bit control word}.
  function automatic dec_t decode(input logic [OPW-1:0] op);
    dec_t d;
    d.legal = (int'(op) < NUM_OPS);
    case (int'(op))
      0, 1, 2, 3: begin d.cls = C_BR;  d.ctrl = 8'hC0; end
      4:          begin d.cls = C_MEM; d.ctrl = 8'hD8; end
      5:          begin d.cls = C_MEM; d.ctrl = 8'h80; end
      6:          begin d.cls = C_BR;  d.ctrl = 8'hC2; end
      7, 8:       begin d.cls = C_BR;  d.ctrl = 8'hC3; end
      15:         begin d.cls = C_MOV; d.ctrl = 8'h90; end
      default:    begin d.cls = C_ALU; d.ctrl = 8'hA4; end
    endcase
    return d;
  endfunction

  state_e           st_q, st_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [CTRLW-1:0] ctrl_q, ctrl_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             mreq_q, mreq_d;
  logic             ret_q, ret_d;
  logic             ill_q, ill_d;
  logic             to_q, to_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  dec_t dec;
  logic wait_last;

  assign dec = decode(op_q);
  // Last permitted wait cycle: a completion seen now still wins over the trap.
  assign wait_last = (wcnt_q == WCW'(TIMEOUT - 1));

  always_comb begin
    st_d   = st_q;
    op_d   = op_q;
    ctrl_d = ctrl_q;
    wcnt_d = wcnt_q;
    mreq_d = 1'b0;
    ret_d  = 1'b0;
    ill_d  = ill_q;
    to_d   = to_q;
    cnt_d  = cnt_q;

    case (st_q)
      S_IDLE: begin
        ctrl_d = '0;
        if (instr_valid) begin
          op_d = opcode;
          st_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!dec.legal) begin
          st_d   = S_TRAP;
          ill_d  = 1'b1;
          ctrl_d = '1;
        end else begin
          ctrl_d = CTRLW'(dec.ctrl);
          st_d   = S_EXEC;
        end
      end

      S_EXEC: begin
        case (dec.cls)
          C_BR, C_MOV: begin
            st_d  = S_WB;
            ret_d = 1'b1;
          end
          C_MEM: begin
            st_d   = S_MEM;
            mreq_d = 1'b1;
          end
          default: begin
            if (alu_done) begin
              st_d  = S_WB;
              ret_d = 1'b1;
            end else if (wait_last) begin
              st_d   = S_TRAP;
              to_d   = 1'b1;
              ctrl_d = '1;
            end else begin
              wcnt_d = wcnt_q + WCW'(1);
            end
          end
        endcase
      end

      S_MEM: begin
        if (mem_ack) begin
          st_d  = S_WB;
          ret_d = 1'b1;
        end else if (wait_last) begin
          st_d   = S_TRAP;
          to_d   = 1'b1;
          ctrl_d = '1;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
          mreq_d = 1'b1;
        end
      end

      S_WB: begin
        cnt_d  = cnt_q + CNTW'(1);
        ctrl_d = '0;
        st_d   = S_IDLE;
      end

      S_TRAP: begin
        if (clear_trap) begin
          ill_d  = 1'b0;
          to_d   = 1'b0;
          ctrl_d = '0;
          st_d   = S_IDLE;
        end
      end

      default: begin
        ctrl_d = '0;
        st_d   = S_IDLE;
      end
    endcase

    // The wait counter measures time spent in the current state only.
    if (st_d != st_q) wcnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      op_q   <= '0;
      ctrl_q <= '0;
      wcnt_q <= '0;
      mreq_q <= 1'b0;
      ret_q  <= 1'b0;
      ill_q  <= 1'b0;
      to_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      op_q   <= op_d;
      ctrl_q <= ctrl_d;
      wcnt_q <= wcnt_d;
      mreq_q <= mreq_d;
      ret_q  <= ret_d;
      ill_q  <= ill_d;
      to_q   <= to_d;
      cnt_q  <= cnt_d;
    end
  end

  assign instr_ready     = (st_q == S_IDLE);
  assign state           = st_q;
  assign control_signals = ctrl_q;
  assign mem_req         = mreq_q;
  assign retire          = ret_q;
  assign illegal         = ill_q;
  assign timeout         = to_q;
  assign ops_retired     = cnt_q;

endmodule
